noc_rr_pkt_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter merging N_REQ AXI-Stream sources (pcpi, mem manager, mem spy, decoder

---
 rtl/noc_arb_pkg.sv | 22 ++
 rtl/axis_skid2.sv | 77 +++++++
 rtl/noc_rr_pkt_arbiter.sv | 160 ++++++++++++++++
 tb/tb_noc_rr_pkt_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types for the tile NoC egress arbiter.
//   arb_state_t : arbiter FSM state (IDLE searches for a requester, LOCKED forwards one packet).
//   axis_beat_t : one AXI-Stream beat at the default 32-bit tile width, packed {data, keep, last}.
//   rr_next     : round-robin successor of a source index, wrapping at n.
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } axis_beat_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// 2-entry in-order registered stream buffer.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_data/keep/last  write one beat (ignored when full)
//   count                   number of buffered beats (0..2), registered
//   out_valid/data/keep/last   head of the buffer, driven straight from flops
//   out_ready               downstream accepts the head this cycle
// Handshake: a beat moves on out_* when out_valid & out_ready at a rising edge.
// The writer is expected to gate push with (count != 2); out_ready only affects
// the pop, so there is no combinational path from out_ready back to the writer.
module axis_skid2 #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [KEEP_W-1:0] push_keep,
    input  logic              push_last,
    output logic [1:0]        count,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int W = DATA_W + KEEP_W + 1;

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [W-1:0] push_beat;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign push_beat = {push_data, push_keep, push_last};
    assign do_push   = push && (cnt_q != 2'd2);
    assign do_pop    = (cnt_q != 2'd0) && out_ready;

    // head_q is always the oldest beat, so a beat pushed into an empty
    // buffer is visible on out_* right after the edge that wrote it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= push_beat;
                    else               tail_q <= push_beat;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= push_beat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count     = cnt_q;
    assign out_valid = (cnt_q != 2'd0);
    assign {out_data, out_keep, out_last} = head_q;

endmodule

// File: rtl/noc_rr_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: merges N_REQ AXI-Stream sources onto the
// tile NoC egress port. A granted source keeps the grant until its TLAST beat
// is accepted; the egress side is a registered 2-entry skid buffer.
// Ports:
//   clk_line, clk_line_rst_low        line clock, asynchronous active-low reset
//   s_TVALID/TDATA/TKEEP/TLAST        per-source streams, source i at slice i
//   s_TREADY                          per-source ready, one-hot or zero
//   m_TVALID/TDATA/TKEEP/TLAST/TREADY egress stream
//   grant_id                          current or last granted source
//   busy                              1 while a packet is locked (FSM state)
//   err_overlong                      sticky, a packet exceeded MAX_BEATS beats
// Handshake (all ports): a beat transfers at a rising edge where VALID & READY;
// VALID never waits for READY, and s_TREADY depends only on registered state.
module noc_rr_pkt_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int KEEP_W    = 4,
    parameter int MAX_BEATS = 256,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BC_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                     clk_line,
    input  logic                     clk_line_rst_low,
    input  logic [N_REQ-1:0]         s_TVALID,
    input  logic [N_REQ*DATA_W-1:0]  s_TDATA,
    input  logic [N_REQ*KEEP_W-1:0]  s_TKEEP,
    input  logic [N_REQ-1:0]         s_TLAST,
    output logic [N_REQ-1:0]         s_TREADY,
    output logic                     m_TVALID,
    output logic [DATA_W-1:0]        m_TDATA,
    output logic [KEEP_W-1:0]        m_TKEEP,
    output logic                     m_TLAST,
    input  logic                     m_TREADY,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     err_overlong
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [BC_W-1:0]   beat_cnt_q;
    logic              err_q;
    logic [1:0]        skid_cnt;

    logic [N_REQ-1:0]  rot;
    logic              found;
    logic [ID_W-1:0]   offset;
    logic [ID_W:0]     sum;
    logic [ID_W-1:0]   pick;

    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_last;
    logic              accept;

    // Priority search: rotate the request vector so bit 0 is rr_ptr, take the
    // first set bit, then map the offset back to a source index modulo N_REQ.
    always_comb begin
        rot    = N_REQ'({s_TVALID, s_TVALID} >> rr_ptr_q);
        found  = 1'b0;
        offset = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                offset = ID_W'(k);
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
        pick = sum[ID_W-1:0];
    end

    // Input mux on the registered grant.
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_data = s_TDATA[i*DATA_W +: DATA_W];
                sel_keep = s_TKEEP[i*KEEP_W +: KEEP_W];
                sel_last = s_TLAST[i];
            end
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) state_q <= ARB_IDLE;
        else                   state_q <= state_d;
    end

    // Next state and FSM outputs. Ready is offered only to the locked source
    // and only while the skid has room.
    always_comb begin
        state_d  = state_q;
        s_TREADY = '0;
        busy     = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (found) state_d = ARB_LOCKED;
            end
            ARB_LOCKED: begin
                busy = 1'b1;
                for (int i = 0; i < N_REQ; i++) begin
                    s_TREADY[i] = (grant_q == ID_W'(i)) && (skid_cnt != 2'd2);
                end
                accept = |(s_TVALID & s_TREADY);
                if (accept && sel_last) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == ARB_IDLE && found) grant_q <= pick;
            if (accept) begin
                if (sel_last) begin
                    beat_cnt_q <= '0;
                    rr_ptr_q   <= ID_W'(rr_next(int'(grant_q), N_REQ));
                end else begin
                    if (beat_cnt_q != BC_W'(MAX_BEATS)) beat_cnt_q <= beat_cnt_q + BC_W'(1);
                    // Overlong packets are still forwarded; only the flag records it.
                    if (beat_cnt_q == BC_W'(MAX_BEATS - 1)) err_q <= 1'b1;
                end
            end
        end
    end

    axis_skid2 #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_skid (
        .clk       (clk_line),
        .rst_n     (clk_line_rst_low),
        .push      (accept),
        .push_data (sel_data),
        .push_keep (sel_keep),
        .push_last (sel_last),
        .count     (skid_cnt),
        .out_valid (m_TVALID),
        .out_data  (m_TDATA),
        .out_keep  (m_TKEEP),
        .out_last  (m_TLAST),
        .out_ready (m_TREADY)
    );

    assign grant_id     = grant_q;
    assign err_overlong = err_q;

endmodule

// File: tb/tb_noc_rr_pkt_arbiter.sv
module tb_noc_rr_pkt_arbiter;
    import noc_arb_pkg::*;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int MAXB = 8;
    localparam int BW   = DW + KW + 1;
    localparam int DEPTH = 512;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    s_tvalid = '0;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*KW-1:0] s_tkeep = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic            m_tready = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_overlong;

    noc_rr_pkt_arbiter #(.N_REQ(N), .DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MAXB)) dut (
        .clk_line         (clk),
        .clk_line_rst_low (rst_n),
        .s_TVALID         (s_tvalid),
        .s_TDATA          (s_tdata),
        .s_TKEEP          (s_tkeep),
        .s_TLAST          (s_tlast),
        .s_TREADY         (s_tready),
        .m_TVALID         (m_tvalid),
        .m_TDATA          (m_tdata),
        .m_TKEEP          (m_tkeep),
        .m_TLAST          (m_tlast),
        .m_TREADY         (m_tready),
        .grant_id         (grant_id),
        .busy             (busy),
        .err_overlong     (err_overlong)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int errors = 0;
    int checks = 0;
    longint cyc = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] src_mem [N][DEPTH];
    int            src_wr [N];
    int            src_rd [N];
    int            acc_cnt [N];
    logic          mid [N];
    int            acc_total = 0;
    int            pop_total = 0;
    logic [N-1:0]  src_en = '0;
    logic [N-1:0]  acc = '0;
    logic          gap_mode = 1'b0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic          gap_chk = 1'b0;
    logic          have_prev = 1'b0;
    longint        prev_cyc = 0;
    int            next_src = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packets are queued in the order they are expected to leave the egress port.
    task automatic push_pkt(input int s, input int len, input bit fixed, input logic [31:0] base);
        axis_beat_t b;
        logic [BW-1:0] v;
        for (int k = 0; k < len; k++) begin
            b.data = fixed ? base + 32'(k) : {8'(s), 24'($urandom)};
            b.keep = 4'($urandom_range(0, 15));
            b.last = (k == len - 1);
            v = b;
            src_mem[s][src_wr[s] % DEPTH] = v;
            src_wr[s]++;
            exp_q.push_back(v);
        end
    endtask

    // ---------------- source and sink driver ----------------
    initial begin : driver
        axis_beat_t db;
        logic       v;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0; src_rd[i] = 0; acc_cnt[i] = 0; mid[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    db = src_mem[i][src_rd[i] % DEPTH];
                    mid[i] = !db.last;
                    src_rd[i]++;
                    acc_cnt[i]++;
                    acc_total++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (src_en[i] && src_rd[i] != src_wr[i]) begin
                    db = src_mem[i][src_rd[i] % DEPTH];
                    v = 1'b1;
                    if (gap_mode && mid[i] && $urandom_range(0, 3) == 0) v = 1'b0;
                    s_tvalid[i]          = v;
                    s_tdata[i*DW +: DW]  = db.data;
                    s_tkeep[i*KW +: KW]  = db.keep;
                    s_tlast[i]           = db.last;
                end else begin
                    s_tvalid[i] = 1'b0;
                end
            end
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [BW-1:0] got;
        logic [BW-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && m_tvalid && m_tready) begin
                got = {m_tdata, m_tkeep, m_tlast};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got %0h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL out_beat: got %0h expected %0h", got, e);
                    end
                end
                pop_total++;
                if (gap_chk) begin
                    if (have_prev) chk("beat_spacing", 64'(cyc - prev_cyc), 64'd2);
                    have_prev = 1'b1;
                    prev_cyc  = cyc;
                end
            end
        end
    end

    task automatic wait_acc(input int s, input int n, input string nm);
        int t = 0;
        while (acc_cnt[s] < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (acc_cnt[s] < n) begin
            checks++; errors++;
            $display("FAIL %s: timeout, accepted %0d expected %0d", nm, acc_cnt[s], n);
        end
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: timeout, %0d beats outstanding expected 0", nm, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_m_tdata"},  64'(m_tdata),  64'd0);
        chk({tag, "_m_tkeep"},  64'(m_tkeep),  64'd0);
        chk({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
        chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_err"},      64'(err_overlong), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin : main
        int base;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        rst_n = 1'b1;
        next_src = 0;
        repeat (2) @(negedge clk);

        // 1: every source streams 1-beat packets, egress always ready.
        rdy_mode = 0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push_pkt((next_src + k) % N, 1, 1'b0, 32'd0);
        gap_chk = 1'b1; have_prev = 1'b0;
        src_en = '1;
        wait_drain("t1_drain");
        gap_chk = 1'b0;
        src_en = '0;
        next_src = 0;

        // 2: src2 5-beat packet; src0 requests during beat 2 and must wait.
        push_pkt(2, 5, 1'b0, 32'd0);
        src_en = 3'b100;
        base = acc_cnt[2] - 5 + 5;
        base = acc_cnt[2];
        wait_acc(2, base + 2, "t2_first_beats");
        push_pkt(0, 1, 1'b0, 32'd0);
        src_en = 3'b101;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (acc_cnt[2] >= base + 5) break;
            chk("t2_s_tready0_held", 64'(s_tready[0]), 64'd0);
            chk("t2_busy", 64'(busy), 64'd1);
            chk("t2_grant_id", 64'(grant_id), 64'd2);
        end
        wait_drain("t2_drain");
        src_en = '0;
        next_src = 1;

        // 3: egress stalls 10 cycles mid-packet; skid holds exactly 2 beats.
        push_pkt(1, 8, 1'b1, 32'hA0);
        src_en = 3'b010;
        base = acc_cnt[1];
        wait_acc(1, base + 2, "t3_start");
        rdy_mode = 2;
        repeat (11) @(negedge clk);
        chk("t3_buffered", 64'(acc_total - pop_total), 64'd2);
        chk("t3_s_tready1", 64'(s_tready[1]), 64'd0);
        chk("t3_m_tvalid", 64'(m_tvalid), 64'd1);
        rdy_mode = 0;
        wait_drain("t3_drain");
        src_en = '0;
        next_src = 2;

        // 4: src2 finishes while src0 and src2 both pend; pointer wraps to src0.
        push_pkt(2, 3, 1'b0, 32'd0);
        push_pkt(0, 1, 1'b0, 32'd0);
        push_pkt(2, 1, 1'b0, 32'd0);
        src_en = 3'b100;
        base = acc_cnt[2];
        wait_acc(2, base + 1, "t4_start");
        src_en = 3'b101;
        wait_drain("t4_drain");
        src_en = '0;
        next_src = 0;

        // Random: all sources backlogged, random lengths, gaps and backpressure.
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < N; k++) push_pkt((next_src + k) % N, $urandom_range(1, MAXB), 1'b0, 32'd0);
        gap_mode = 1'b1; rdy_mode = 1;
        src_en = '1;
        wait_drain("rand_drain");
        src_en = '0;
        gap_mode = 1'b0; rdy_mode = 0;
        chk("rand_err_clear", 64'(err_overlong), 64'd0);

        // 5: MAX_BEATS boundary. 8 beats is legal, 9 beats sets the flag.
        push_pkt(1, 8, 1'b0, 32'd0);
        src_en = 3'b010;
        wait_drain("t5_legal_drain");
        chk("t5_err_after_8", 64'(err_overlong), 64'd0);
        push_pkt(1, 9, 1'b0, 32'd0);
        base = acc_cnt[1];
        wait_acc(1, base + 7, "t5_beat7");
        chk("t5_err_before_beat8", 64'(err_overlong), 64'd0);
        wait_acc(1, base + 8, "t5_beat8");
        chk("t5_err_at_beat8", 64'(err_overlong), 64'd1);
        wait_drain("t5_long_drain");
        push_pkt(1, 2, 1'b0, 32'd0);
        wait_drain("t5_next_drain");
        chk("t5_err_sticky", 64'(err_overlong), 64'd1);
        src_en = '0;

        // 6: reset mid-packet, then first grant must come from src0.
        push_pkt(1, 6, 1'b0, 32'd0);
        src_en = 3'b010;
        base = acc_cnt[1];
        wait_acc(1, base + 3, "t6_start");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        src_en = '0;
        acc = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            src_rd[i] = src_wr[i];
            mid[i] = 1'b0;
        end
        #1;
        chk_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_src = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) push_pkt((next_src + k) % N, $urandom_range(1, 4), 1'b0, 32'd0);
        src_en = '1;
        wait_drain("t6_drain");
        src_en = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
